instr_fetch_unit: RTL

//  Instruction fetch stage between program_counter-style PC generation and the decoder/control block.

---
 rtl/instr_fetch_unit.sv | 127 ++++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: issues in-order word reads to instruction memory, buffers
// returned words with their PCs in a small FIFO toward decode, and flushes on redirect.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2,
  parameter int          MAX_OUT    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr
);

  // Handshakes: a transfer happens on a rising edge where valid & ready are both high.
  // A request held while not ready keeps its address; it is withdrawn only by redirect.
  // Responses carry no ready: exactly one arrives per accepted request, in order.

  localparam int CW = $clog2(FIFO_DEPTH + MAX_OUT + 1) + 1;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] MAXO_C   = CW'(MAX_OUT);
  localparam logic [PW-1:0] LAST_IDX = PW'(FIFO_DEPTH - 1);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   rsp_pc_q, rsp_pc_d;
  logic [CW-1:0] live_q, live_d;
  logic [CW-1:0] stale_q, stale_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [31:0]   fifo_pc_q    [FIFO_DEPTH];
  logic [31:0]   fifo_instr_q [FIFO_DEPTH];

  logic accept, pop, drop, push, fifo_we, rsp_owned;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_IDX) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    imem_req_valid = rst & ~redirect
                   & (live_q + count_q < DEPTH_C)
                   & (live_q + stale_q < MAXO_C);
    imem_req_addr  = fetch_pc_q;
    if_valid       = (count_q != '0);
    if_pc          = if_valid ? fifo_pc_q[rd_ptr_q]    : 32'h0;
    if_instr       = if_valid ? fifo_instr_q[rd_ptr_q] : 32'h0;

    accept    = imem_req_valid & imem_req_ready;
    pop       = if_valid & if_ready;
    drop      = imem_rsp_valid & (stale_q != '0);
    push      = imem_rsp_valid & (stale_q == '0) & (live_q != '0);
    rsp_owned = imem_rsp_valid & ((stale_q != '0) | (live_q != '0));

    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    live_d     = live_q;
    stale_d    = stale_q;
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fifo_we    = 1'b0;

    if (redirect) begin
      // Everything in flight becomes stale; a response landing now is already dropped.
      fetch_pc_d = {redirect_target[31:2], 2'b00};
      rsp_pc_d   = {redirect_target[31:2], 2'b00};
      stale_d    = stale_q + live_q - {{(CW-1){1'b0}}, rsp_owned};
      live_d     = '0;
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
    end else begin
      if (accept) fetch_pc_d = fetch_pc_q + 32'd4;
      if (drop)   stale_d    = stale_q - 1'b1;
      if (push) begin
        fifo_we  = 1'b1;
        rsp_pc_d = rsp_pc_q + 32'd4;
        wr_ptr_d = ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
      live_d  = live_q + {{(CW-1){1'b0}}, accept} - {{(CW-1){1'b0}}, push};
      count_d = count_q + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      live_q     <= '0;
      stale_q    <= '0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      live_q     <= live_d;
      stale_q    <= stale_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // Storage needs no reset: entries are only visible while counted as occupied.
  always_ff @(posedge clk) begin
    if (fifo_we) begin
      fifo_pc_q[wr_ptr_q]    <= rsp_pc_q;
      fifo_instr_q[wr_ptr_q] <= imem_rsp_data;
    end
  end

  rsp_has_owner: assert property (@(posedge clk) disable iff (!rst)
    imem_rsp_valid |-> ((live_q != '0) || (stale_q != '0)));

endmodule
